// File: rtl/alu_op_issuer_if.sv
// Decode-side request and writeback-side response bundle for alu_op_issuer.
// A transfer happens on the rising edge where valid and ready are both 1; the source holds its payload until then.
interface alu_op_issuer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_aluop;
    logic [5:0]            req_funct;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_zero;
    logic                  rsp_err;

    modport master (
        output req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_aluop, req_funct, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues one decoded operation to the ALU, holds operands for its settle time, returns the result.
// Define ALU_ISSUE_MUL_EN to decode funct 011000 as MUL with a MUL_CYCLES-long hold.
module alu_op_issuer #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_op_issuer_if.slave        bus,
    output logic [DATA_WIDTH-1:0] alu_in_0,
    output logic [DATA_WIDTH-1:0] alu_in_1,
    output logic [2:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_zero,
    output logic [1:0]            dbg_state
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EXEC     = 2'd1;
`ifdef ALU_ISSUE_MUL_EN
    localparam logic [1:0] S_WAIT_MUL = 2'd2;
    localparam logic [2:0] SEL_MUL    = 3'b101;
    localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 1);
`endif
    localparam logic [1:0] S_RESP     = 2'd3;

    localparam logic [2:0] SEL_AND  = 3'b000;
    localparam logic [2:0] SEL_OR   = 3'b001;
    localparam logic [2:0] SEL_ADD  = 3'b010;
    localparam logic [2:0] SEL_SUB  = 3'b100;
    localparam logic [2:0] SEL_SLT  = 3'b110;
    localparam logic [2:0] SEL_IDLE = 3'b111;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] rsp_result_q;
    logic                  rsp_zero_q;
    logic                  rsp_err_q;
    logic [2:0]            dec_sel;
    logic                  dec_legal;
`ifdef ALU_ISSUE_MUL_EN
    logic                  dec_mul;
    logic [3:0]            cnt;
`endif

    always_comb begin
        dec_sel   = SEL_IDLE;
        dec_legal = 1'b0;
`ifdef ALU_ISSUE_MUL_EN
        dec_mul   = 1'b0;
`endif
        case (bus.req_aluop)
            2'b00: begin dec_sel = SEL_ADD; dec_legal = 1'b1; end
            2'b01: begin dec_sel = SEL_SUB; dec_legal = 1'b1; end
            2'b10: begin
                case (bus.req_funct)
                    6'b100000: begin dec_sel = SEL_ADD; dec_legal = 1'b1; end
                    6'b100010: begin dec_sel = SEL_SUB; dec_legal = 1'b1; end
                    6'b100100: begin dec_sel = SEL_AND; dec_legal = 1'b1; end
                    6'b100101: begin dec_sel = SEL_OR;  dec_legal = 1'b1; end
                    6'b101010: begin dec_sel = SEL_SLT; dec_legal = 1'b1; end
`ifdef ALU_ISSUE_MUL_EN
                    6'b011000: begin dec_sel = SEL_MUL; dec_legal = 1'b1; dec_mul = 1'b1; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            alu_in_0     <= '0;
            alu_in_1     <= '0;
            alu_sel      <= SEL_IDLE;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
`ifdef ALU_ISSUE_MUL_EN
            cnt          <= 4'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        alu_in_0 <= bus.req_a;
                        alu_in_1 <= bus.req_b;
                        alu_sel  <= dec_sel;
                        // Illegal ops never reach the ALU; their response is formed here.
                        if (!dec_legal) begin
                            rsp_result_q <= '0;
                            rsp_zero_q   <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            state        <= S_RESP;
`ifdef ALU_ISSUE_MUL_EN
                        end else if (dec_mul) begin
                            cnt   <= MUL_LOAD;
                            state <= S_WAIT_MUL;
`endif
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_result_q <= alu_out;
                    rsp_zero_q   <= alu_zero;
                    rsp_err_q    <= 1'b0;
                    state        <= S_RESP;
                end
`ifdef ALU_ISSUE_MUL_EN
                S_WAIT_MUL: begin
                    if (cnt == 4'd0) begin
                        rsp_result_q <= alu_out;
                        rsp_zero_q   <= alu_zero;
                        rsp_err_q    <= 1'b0;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`endif
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        alu_sel <= SEL_IDLE;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.rsp_valid  = (state == S_RESP);
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_alu_op_issuer.sv
// Bench for alu_op_issuer with a behavioural ALU; expected responses queued at issue and popped at response.
module tb_alu_op_issuer;
    localparam int DW = 32;
    localparam int MC = 4;
    localparam int W  = DW + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_issuer_if #(.DATA_WIDTH(DW)) bus ();
    logic [DW-1:0] alu_in_0, alu_in_1, alu_out;
    logic [2:0]    alu_sel;
    logic          alu_zero;
    logic [1:0]    dbg_state;

    alu_op_issuer #(.DATA_WIDTH(DW), .MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero), .dbg_state(dbg_state)
    );

    // behavioural ALU
    always_comb begin
        case (alu_sel)
            3'b000:  alu_out = alu_in_0 & alu_in_1;
            3'b001:  alu_out = alu_in_0 | alu_in_1;
            3'b010:  alu_out = alu_in_0 + alu_in_1;
            3'b100:  alu_out = alu_in_0 - alu_in_1;
            3'b101:  alu_out = alu_in_0 * alu_in_1;
            3'b110:  alu_out = ($signed(alu_in_0) < $signed(alu_in_1)) ? 32'd1 : 32'd0;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] pack(input logic e, input logic z, input logic [DW-1:0] r);
        return {e, z, r};
    endfunction

    task automatic drive_req(input logic [1:0] op, input logic [5:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_aluop = op;
        bus.req_funct = f;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [W-1:0] got);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {bus.rsp_err, bus.rsp_zero, bus.rsp_result};
    endtask

    task automatic finish_rsp;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_hs got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
        end
        n_cmp++;
        if (alu_in_0 !== '0 || alu_in_1 !== '0 || alu_sel !== 3'b111) begin
            n_err++; $display("FAIL reset_alu got %h %h %b want 0 0 111", alu_in_0, alu_in_1, alu_sel);
        end
        n_cmp++;
        if ({bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== pack(1'b0, 1'b0, '0)) begin
            n_err++; $display("FAIL reset_rsp got %h want 0", {bus.rsp_err, bus.rsp_zero, bus.rsp_result});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_funct;
        int lat; logic [W-1:0] got, exp;
        exp_q.push_back(pack(1'b0, 1'b0, 32'd12));
        drive_req(2'b10, 6'b100000, 32'd7, 32'd5);
        n_cmp++;
        if (alu_sel !== 3'b010) begin n_err++; $display("FAIL add_sel got %b want 010", alu_sel); end
        wait_rsp(lat, got);
        n_cmp++;
        if (lat !== 1) begin n_err++; $display("FAIL add_lat got %0d want 1", lat); end
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL add_rsp got %h want %h", got, exp); end
        finish_rsp;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || alu_sel !== 3'b111) begin
            n_err++; $display("FAIL add_done got ready=%b valid=%b sel=%b want 1 0 111", bus.req_ready, bus.rsp_valid, alu_sel);
        end
    endtask

    task automatic test_sub_zero;
        int lat; logic [W-1:0] got, exp;
        exp_q.push_back(pack(1'b0, 1'b1, 32'd0));
        drive_req(2'b01, 6'b000000, 32'h1234, 32'h1234);
        n_cmp++;
        if (alu_sel !== 3'b100) begin n_err++; $display("FAIL sub_sel got %b want 100", alu_sel); end
        wait_rsp(lat, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp || lat !== 1) begin n_err++; $display("FAIL sub_rsp got %h lat %0d want %h lat 1", got, lat, exp); end
        finish_rsp;
    endtask

    task automatic test_illegal;
        int lat; logic [W-1:0] got, exp;
        logic [1:0] ops[2] = '{2'b11, 2'b10};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(pack(1'b1, 1'b1, 32'd0));
            drive_req(ops[i], 6'b000111, 32'd55, 32'd66);
            n_cmp++;
            if (alu_sel !== 3'b111) begin n_err++; $display("FAIL ill_sel[%0d] got %b want 111", i, alu_sel); end
            wait_rsp(lat, got);
            n_cmp++;
            if (lat !== 0) begin n_err++; $display("FAIL ill_lat[%0d] got %0d want 0", i, lat); end
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL ill_rsp[%0d] got %h want %h", i, got, exp); end
            finish_rsp;
        end
    endtask

    task automatic test_mul;
        int lat; logic [W-1:0] got, exp;
`ifdef ALU_ISSUE_MUL_EN
        exp_q.push_back(pack(1'b0, 1'b0, 32'd42));
        drive_req(2'b10, 6'b011000, 32'd6, 32'd7);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            n_cmp++;
            if (alu_in_0 !== 32'd6 || alu_in_1 !== 32'd7 || alu_sel !== 3'b101) begin
                n_err++; $display("FAIL mul_hold got %h %h %b want 6 7 101", alu_in_0, alu_in_1, alu_sel);
            end
            @(posedge clk); #1;
            lat++;
        end
        got = {bus.rsp_err, bus.rsp_zero, bus.rsp_result};
        n_cmp++;
        if (lat !== MC) begin n_err++; $display("FAIL mul_lat got %0d want %0d", lat, MC); end
`else
        exp_q.push_back(pack(1'b1, 1'b1, 32'd0));
        drive_req(2'b10, 6'b011000, 32'd6, 32'd7);
        n_cmp++;
        if (alu_sel !== 3'b111) begin n_err++; $display("FAIL mul_off_sel got %b want 111", alu_sel); end
        wait_rsp(lat, got);
        n_cmp++;
        if (lat !== 0) begin n_err++; $display("FAIL mul_off_lat got %0d want 0", lat); end
`endif
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mul_rsp got %h want %h", got, exp); end
        finish_rsp;
    endtask

    task automatic test_random_ops;
        int lat; logic [W-1:0] got, exp;
        logic [DW-1:0] a, b, r; logic [1:0] op; logic [5:0] f; logic [2:0] sel;
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom;
            if (i == 0) begin a = 32'd3; b = 32'd9; end
            case (i == 0 ? 4 : $urandom_range(0, 5))
                0: begin op = 2'b00; f = 6'($urandom); sel = 3'b010; r = a + b; end
                1: begin op = 2'b01; f = 6'($urandom); sel = 3'b100; r = a - b; end
                2: begin op = 2'b10; f = 6'b100100; sel = 3'b000; r = a & b; end
                3: begin op = 2'b10; f = 6'b100101; sel = 3'b001; r = a | b; end
                4: begin op = 2'b10; f = 6'b101010; sel = 3'b110; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                default: begin op = 2'b10; f = 6'b100010; sel = 3'b100; r = a - b; end
            endcase
            exp_q.push_back(pack(1'b0, r == '0, r));
            drive_req(op, f, a, b);
            n_cmp++;
            if (alu_sel !== sel) begin n_err++; $display("FAIL rnd_sel[%0d] got %b want %b", i, alu_sel, sel); end
            wait_rsp(lat, got);
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp || lat !== 1) begin n_err++; $display("FAIL rnd_rsp[%0d] got %h lat %0d want %h lat 1", i, got, lat, exp); end
            finish_rsp;
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [W-1:0] got, exp;
        bus.rsp_ready = 1'b0;
        exp_q.push_back(pack(1'b0, 1'b0, 32'h30));
        drive_req(2'b00, 6'b000000, 32'h10, 32'h20);
        wait_rsp(lat, got);
        exp = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            bus.req_aluop = 2'b01; bus.req_a = 32'd1; bus.req_b = 32'd1; bus.req_valid = 1'b1;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            n_cmp++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || {bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== exp) begin
                n_err++; $display("FAIL bp_hold[%0d] got valid=%b ready=%b rsp=%h want 1 0 %h", i, bus.rsp_valid, bus.req_ready,
                                  {bus.rsp_err, bus.rsp_zero, bus.rsp_result}, exp);
            end
        end
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL bp_rsp got %h want %h", got, exp); end
        finish_rsp;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_ignored got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [W-1:0] got, exp;
        exp_q.push_back(pack(1'b0, 1'b0, 32'd3));
        exp_q.push_back(pack(1'b0, 1'b0, 32'hF0));
        drive_req(2'b00, 6'b000000, 32'd1, 32'd2);
        wait_rsp(lat, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL b2b_first got %h want %h", got, exp); end
        bus.req_aluop = 2'b10; bus.req_funct = 6'b100101; bus.req_a = 32'hC0; bus.req_b = 32'h30;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (alu_sel !== 3'b111 || bus.req_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_noaccept got sel=%b ready=%b want 111 1", alu_sel, bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (alu_sel !== 3'b001) begin n_err++; $display("FAIL b2b_sel got %b want 001", alu_sel); end
        wait_rsp(lat, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp || lat !== 1) begin n_err++; $display("FAIL b2b_second got %h lat %0d want %h lat 1", got, lat, exp); end
        finish_rsp;
    endtask

    task automatic test_reset_mid;
        int lat; logic [W-1:0] got, exp;
        bus.rsp_ready = 1'b0;
        drive_req(2'b10, 6'b011000, 32'd9, 32'd9);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || alu_sel !== 3'b111 || alu_in_0 !== '0 || alu_in_1 !== '0) begin
            n_err++; $display("FAIL rstmid_ctl got ready=%b valid=%b sel=%b in=%h/%h want 1 0 111 0/0",
                              bus.req_ready, bus.rsp_valid, alu_sel, alu_in_0, alu_in_1);
        end
        n_cmp++;
        if ({bus.rsp_err, bus.rsp_zero, bus.rsp_result} !== pack(1'b0, 1'b0, '0)) begin
            n_err++; $display("FAIL rstmid_rsp got %h want 0", {bus.rsp_err, bus.rsp_zero, bus.rsp_result});
        end
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(pack(1'b0, 1'b0, 32'd123));
        drive_req(2'b00, 6'b000000, 32'd100, 32'd23);
        wait_rsp(lat, got);
        exp = exp_q.pop_front();
        n_cmp++;
        if (got !== exp || lat !== 1) begin n_err++; $display("FAIL rstmid_next got %h lat %0d want %h lat 1", got, lat, exp); end
        finish_rsp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_aluop = 2'b00;
        bus.req_funct = 6'b000000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        test_reset;
        test_add_funct;
        test_sub_zero;
        test_illegal;
        test_mul;
        test_random_ops;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Sequential front end that drives the datapath ALU's operand/select interface. Accepts one operation per valid/ready handshake from the decode stage (ALUOp + funct + two operands), encodes the 3-bit ALU select, and holds the operands stable for the ALU's settle time: one cycle, or MUL_CYCLES cycles for multiply. It then registers the ALU result and zero flag and presents them on a valid/ready response port. Sits between instruction decode and the ALU/writeback path.

## Interface
- DATA_WIDTH, 32, operand/result width (must match the ALU)
- MUL_CYCLES, 4, cycles the operands are held for a MUL before capture; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_aluop  input  2  00 = add, 01 = sub, 10 = R-type (use funct), 11 = illegal
- req_funct  input  6  MIPS funct field
- req_a, req_b  input  DATA_WIDTH  operands
- alu_in_0, alu_in_1  output  DATA_WIDTH  registered operands to the ALU
- alu_sel  output  3  registered ALU select
- alu_out  input  DATA_WIDTH  ALU result
- alu_zero  input  1  ALU zero flag
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_result  output  DATA_WIDTH  captured result
- rsp_zero  output  1  captured zero flag
- rsp_err  output  1  request was illegal

## Operation
- Select encoding: AND=000, OR=001, ADD=010, SUB=100, MUL=101, SLT=110. 111 is the idle/illegal code; the ALU returns 0 for it.
- Decode by ALUOp:
  - 00 → ADD
  - 01 → SUB
  - 10 → by funct: 100000 → ADD; 100010 → SUB; 100100 → AND; 100101 → OR; 101010 → SLT; 011000 → MUL
  - 10 with any other funct, or ALUOp 11 → illegal
- FSM states: IDLE, EXEC, WAIT_MUL, RESP.
- IDLE:
  - req_ready=1; no other state drives req_ready high.
  - On req_valid, register req_a→alu_in_0, req_b→alu_in_1, and the encoded sel→alu_sel.
  - Next state: EXEC for legal non-MUL ops; WAIT_MUL for MUL, with the counter loaded to MUL_CYCLES-1; RESP for illegal ops.
  - Illegal ops set rsp_result=0, rsp_zero=1, rsp_err=1, and alu_sel=111.
- EXEC: lasts one cycle. At its closing edge, capture alu_out→rsp_result and alu_zero→rsp_zero, clear rsp_err, go to RESP.
- WAIT_MUL:
  - The counter decrements each cycle.
  - On the edge where the counter is 0, capture the result exactly as in EXEC and go to RESP.
  - Counter width: 4 bits.
- RESP:
  - rsp_valid=1; rsp_result, rsp_zero and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, go to IDLE and set alu_sel=111.
- alu_in_0, alu_in_1 and alu_sel change only at request capture and when leaving RESP; they are stable during EXEC and WAIT_MUL.
- Arithmetic is performed entirely in the ALU. The block never modifies operands, and results are DATA_WIDTH bits truncated as the ALU produces them.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, alu_in_0=0, alu_in_1=0, alu_sel=111, rsp_result=0, rsp_zero=0, rsp_err=0, counter=0.
- Let the request handshake occur at edge T. rsp_valid is first high after:
  - edge T+1 for legal non-MUL ops;
  - edge T+MUL_CYCLES for MUL;
  - edge T for illegal ops.
- With rsp_ready held at 1, the response handshake occurs at the first edge where rsp_valid=1. req_ready returns to 1 after that edge.
- Throughput: at most one request in flight. No request is accepted in the cycle of the response handshake.
- req_valid is ignored outside IDLE; it is not latched.
- Asserting rst mid-operation aborts immediately: all outputs take their reset values and any in-flight result is discarded.
- MUL_CYCLES=1 behaves identically to EXEC timing.

## Configuration
- ALU_ISSUE_MUL_EN defined: funct 011000 decodes to MUL and uses the WAIT_MUL path.
- ALU_ISSUE_MUL_EN undefined:
  - funct 011000 is illegal (rsp_err=1, rsp_result=0).
  - WAIT_MUL and its counter are not built.
  - alu_sel never takes the value 101.

## Test plan
- Reset mid-MUL (rst pulsed during WAIT_MUL) → all outputs return to reset values asynchronously; the next request completes normally.
- ALUOp=10, funct=100000, a=7, b=5 → alu_sel=010; rsp_valid after T+1; rsp_result=12, rsp_zero=0, rsp_err=0.
- ALUOp=01, a=b=0x1234 → alu_sel=100; rsp_result=0, rsp_zero=1.
- ALUOp=10, funct=011000, a=6, b=7, MUL_CYCLES=4, macro defined → operands stable for 4 cycles; rsp_result=42 after T+4. With the macro undefined → rsp_err=1, rsp_result=0.
- ALUOp=11 → response after T with rsp_err=1, rsp_zero=1, alu_sel=111. ALUOp=10, funct=101010, a=3, b=9 → rsp_result=1.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_valid and rsp_result held; req_ready=0; req_valid pulses are ignored.
